prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the FSM state encoding, the hi-byte nibble mask and the default capacity.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] HI_MASK      = 8'hF0;
    localparam int         MAX_INST_DEF = 10;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: count, {hi,lo} instruction pairs, checksum.
// Writes each assembled 12-bit instruction to program memory as it arrives.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_INST = MAX_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        load_we,
    output logic [7:0]  load_addr,
    output logic [11:0] load_inst,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  inst_count
);

    localparam logic [8:0] MAX_N = 9'(MAX_INST);

    state_t     state;
    state_t     state_nx;
    logic [7:0] n_q;
    logic [7:0] csum;
    logic [3:0] hi_q;
    logic       xfer;
    logic       last;
    logic       cnt_bad;
    logic       hi_bad;
    logic       sess_start;

    // Reset is folded in so nothing transfers or writes while rst is low.
    assign in_ready = rst && (state == S_COUNT || state == S_HI ||
                              state == S_LO    || state == S_CHECK);
    assign load_we  = rst && (state == S_WRITE);

    assign xfer       = in_valid && in_ready;
    assign last       = ({1'b0, inst_count} + 9'd1) == {1'b0, n_q};
    assign cnt_bad    = (in_data == 8'd0) || ({1'b0, in_data} > MAX_N);
    assign hi_bad     = (in_data & HI_MASK) != 8'h00;
    assign sess_start = start && (state == S_IDLE || state == S_DONE ||
                                  state == S_ERR);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nx = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) state_nx = cnt_bad ? S_ERR : S_HI;
            end
            S_HI: begin
                if (xfer) state_nx = hi_bad ? S_ERR : S_LO;
            end
            S_LO: begin
                if (xfer) state_nx = S_WRITE;
            end
            S_WRITE: begin
                state_nx = last ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (xfer) state_nx = (in_data == csum) ? S_DONE : S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: count latch, instruction assembly, address and checksum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q        <= '0;
            csum       <= '0;
            hi_q       <= '0;
            load_addr  <= '0;
            load_inst  <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            inst_count <= '0;
        end else begin
            if (sess_start) begin
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                inst_count <= '0;
                load_addr  <= '0;
                csum       <= '0;
            end
            unique case (state)
                S_COUNT: begin
                    if (xfer) begin
                        if (cnt_bad) load_err <= 1'b1;
                        else         n_q      <= in_data;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        if (hi_bad) begin
                            load_err <= 1'b1;
                        end else begin
                            hi_q <= in_data[3:0];
                            csum <= csum + in_data;
                        end
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        load_inst <= {hi_q, in_data};
                        csum      <= csum + in_data;
                    end
                end
                S_WRITE: begin
                    load_addr  <= load_addr + 8'd1;
                    inst_count <= inst_count + 8'd1;
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (in_data == csum) load_done <= 1'b1;
                        else                 load_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader.
// A stream-level model predicts writes and session outcome.
module tb_prog_loader;

    localparam int MAXI = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [11:0] load_inst;
    logic        load_done;
    logic        load_err;
    logic [7:0]  inst_count;

    prog_loader #(.MAX_INST(MAXI)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_inst (load_inst),
        .load_done (load_done),
        .load_err  (load_err),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]  stim[$];
    logic [19:0] exp_w[$];
    logic [19:0] seen[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_cnt;
    int          consumed;

    int sess     = 0;
    int mon_sess = 0;
    int cyc      = 0;
    int acc      = 0;
    int wr       = 0;
    int last_x   = -10;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Stream-level reference: what a correct loader does with stim.
    task automatic model();
        int n;
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        exp_w.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        sum      = 8'd0;
        n        = int'(stim[0]);
        consumed = 1;
        if (n == 0 || n > MAXI) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            hi = stim[1 + 2 * i];
            if (hi >= 8'd16) begin
                exp_err  = 1'b1;
                consumed = 2 + 2 * i;
                return;
            end
            lo = stim[2 + 2 * i];
            exp_w.push_back({8'(i), hi[3:0], lo});
            sum = sum + hi + lo;
            exp_cnt++;
        end
        consumed = 2 + 2 * n;
        exp_done = (stim[1 + 2 * n] == sum);
        exp_err  = !exp_done;
    endtask

    task automatic monitor();
        logic [19:0] w;
        forever begin
            @(negedge clk);
            cyc++;
            if (sess != mon_sess) begin
                mon_sess = sess;
                acc      = 0;
                wr       = 0;
                seen.delete();
            end
            if (load_we) begin
                chk("we_in_ready", 32'(in_ready), 32'd0);
                if (exp_w.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr %0h inst %0h",
                             load_addr, load_inst);
                end else begin
                    w = exp_w.pop_front();
                    chk("write_addr", 32'(load_addr), 32'(w[19:12]));
                    chk("write_inst", 32'(load_inst), 32'(w[11:0]));
                    chk("write_latency", 32'(last_x), 32'(cyc - 1));
                    chk("write_order", 32'(acc), 32'(2 * wr + 3));
                end
                seen.push_back({load_addr, load_inst});
                wr++;
            end
            if (in_valid && in_ready) begin
                acc++;
                last_x = cyc;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        int  w   = 0;
        bit  got = 1'b0;
        while (!got && w < 200) begin
            in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? b : 8'($urandom);
            @(negedge clk);
            got = in_valid && in_ready;
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            $display("FAIL byte_timeout: byte %0h not accepted", b);
        end
    endtask

    task automatic session(input bit bp, input int busy_at);
        model();
        sess++;
        pulse_start();
        for (int i = 0; i < consumed; i++) begin
            send_byte(stim[i], bp);
            if (i == busy_at) pulse_start();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("load_done", 32'(load_done), 32'(exp_done));
        chk("load_err", 32'(load_err), 32'(exp_err));
        chk("inst_count", 32'(inst_count), 32'(exp_cnt));
        chk("writes_pending", 32'(exp_w.size()), 32'd0);
        chk("bytes_accepted", 32'(acc), 32'(consumed));
        @(posedge clk); #1;
    endtask

    task automatic set_stim(input logic [7:0] a[]);
        stim.delete();
        foreach (a[i]) stim.push_back(a[i]);
    endtask

    task automatic nominal(input logic [7:0] ck);
        logic [7:0] a[];
        a = '{8'h02, 8'h01, 8'h23, 8'h04, 8'h56, ck};
        set_stim(a);
    endtask

    task automatic gen_random();
        int n;
        int kind;
        logic [7:0] sum;
        logic [7:0] b;
        stim.delete();
        sum  = 8'd0;
        kind = $urandom_range(0, 9);
        n    = $urandom_range(1, MAXI);
        if (kind == 0) n = 0;
        if (kind == 1) n = $urandom_range(MAXI + 1, 255);
        stim.push_back(8'(n));
        if (kind <= 1) return;
        for (int i = 0; i < n; i++) begin
            b = {4'h0, 4'($urandom)};
            if (kind == 2 && i == n - 1) b[7:4] = 4'($urandom_range(1, 15));
            stim.push_back(b);
            sum = sum + b;
            b = 8'($urandom);
            stim.push_back(b);
            sum = sum + b;
        end
        if (kind == 3) sum = sum + 8'($urandom_range(1, 255));
        stim.push_back(sum);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a[];
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_load_we", 32'(load_we), 32'd0);
        chk("rst_load_addr", 32'(load_addr), 32'd0);
        chk("rst_load_inst", 32'(load_inst), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_inst_count", 32'(inst_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        nominal(8'h7E);
        session(1'b0, -1);
        chk("nom_w0", 32'(seen.size() > 0 ? seen[0] : 20'hFFFFF), 32'h00123);
        chk("nom_w1", 32'(seen.size() > 1 ? seen[1] : 20'hFFFFF), 32'h01456);
        chk("nom_done", 32'(load_done), 32'd1);
        chk("nom_count", 32'(inst_count), 32'd2);

        nominal(8'h7F);
        session(1'b0, -1);
        chk("badck_err", 32'(load_err), 32'd1);
        chk("badck_writes", 32'(seen.size()), 32'd2);

        a = '{8'h00};
        set_stim(a);
        session(1'b0, -1);
        chk("cnt0_err", 32'(load_err), 32'd1);

        a = '{8'h0B};
        set_stim(a);
        session(1'b0, -1);
        chk("cnt11_err", 32'(load_err), 32'd1);

        a = '{8'h02, 8'h11};
        set_stim(a);
        session(1'b0, -1);
        chk("hi_err", 32'(load_err), 32'd1);
        chk("hi_count", 32'(inst_count), 32'd0);

        nominal(8'h7E);
        session(1'b1, -1);
        chk("bp_done", 32'(load_done), 32'd1);

        nominal(8'h7E);
        model();
        exp_w.delete();
        sess++;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_load_we", 32'(load_we), 32'd0);
        chk("mrst_load_addr", 32'(load_addr), 32'd0);
        chk("mrst_load_inst", 32'(load_inst), 32'd0);
        chk("mrst_flags", 32'({load_done, load_err}), 32'd0);
        chk("mrst_inst_count", 32'(inst_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        nominal(8'h7E);
        session(1'b1, -1);
        chk("post_rst_done", 32'(load_done), 32'd1);

        rst   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_prio_ready", 32'(in_ready), 32'd0);
        chk("rst_prio_done", 32'(load_done), 32'd0);
        @(posedge clk); #1;

        stim.delete();
        stim.push_back(8'd10);
        begin
            logic [7:0] s;
            s = 8'd0;
            for (int i = 0; i < 10; i++) begin
                stim.push_back(8'h00);
                stim.push_back(8'(i));
                s = s + 8'(i);
            end
            stim.push_back(s);
        end
        session(1'b1, 6);
        chk("full_done", 32'(load_done), 32'd1);
        chk("full_count", 32'(inst_count), 32'd10);
        chk("full_last", 32'(seen.size() == 10 ? seen[9] : 20'hFFFFF),
            32'h09009);

        for (int k = 0; k < 30; k++) begin
            gen_random();
            session(1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0 ? 2 : -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
